// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver state encoding.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 33;
  localparam int unsigned UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module synchronizer #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM that emits each byte as a one-cycle valid pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      uart_rxd_in,
  output logic [UART_DATA_BITS-1:0] byte_out,
  output logic                      valid_out,
  output logic                      framing_err_out
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  logic                      rxd_sync;
  rx_state_t                 state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [BIT_W-1:0]          bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] byte_q;
  logic                      valid_q;
  logic                      ferr_q;

  synchronizer #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_rxd_sync (
    .clk_i (clk_in),
    .rst_ni(rst_in),
    .d_i   (uart_rxd_in),
    .q_o   (rxd_sync)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (!rxd_sync) state_q <= RX_START;
        end
        // A line that is high again at mid start bit was only a glitch.
        RX_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= {rxd_sync, shift_q[UART_DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) state_q <= RX_STOP;
            else                   bit_q   <= bit_q + BIT_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        RX_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            if (rxd_sync) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= RX_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RX_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        // A held-low (break) line must not decode as a stream of zero bytes.
        RX_WAIT_HIGH: begin
          if (rxd_sync) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_out        = byte_q;
  assign valid_out       = valid_q;
  assign framing_err_out = ferr_q;

endmodule
